// File: rtl/hazard_detection.sv
// rtl/hazard_detection.sv - pipeline hazard unit: load-use/branch stalls, memory freeze, perf counters
module hazard_detection (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rsIfId,
  input  logic [4:0]  rtIfId,
  input  logic        useRtId,
  input  logic        branchId,
  input  logic        branchTaken,
  input  logic        memReadIdEx,
  input  logic        regWriteIdEx,
  input  logic [4:0]  rtIdEx,
  input  logic [4:0]  rdIdEx,
  input  logic        memReadExMem,
  input  logic [4:0]  rdExMem,
  input  logic        memBusy,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        idExBubble,
  output logic        ifIdFlush,
  output logic        pipeFreeze,
  output logic [15:0] stallCount,
  output logic [15:0] freezeCount
);

  typedef enum logic {RUN, STALL} state_t;

  state_t     state;
  logic [1:0] remaining;
  logic       load_use, br_ex, br_load_ex, br_mem;
  logic [1:0] stall_len;

  // Register zero is hardwired, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 5'd0);
  endfunction

  always_comb begin
    load_use   = memReadIdEx &&
                 (reg_match(rtIdEx, rsIfId) || (useRtId && reg_match(rtIdEx, rtIfId)));
    br_ex      = branchId && regWriteIdEx && !memReadIdEx &&
                 (reg_match(rdIdEx, rsIfId) || reg_match(rdIdEx, rtIfId));
    br_load_ex = branchId && memReadIdEx &&
                 (reg_match(rtIdEx, rsIfId) || reg_match(rtIdEx, rtIfId));
    br_mem     = branchId && memReadExMem &&
                 (reg_match(rdExMem, rsIfId) || reg_match(rdExMem, rtIfId));
    if (br_load_ex)
      stall_len = 2'd2;
    else if (load_use || br_ex || br_mem)
      stall_len = 2'd1;
    else
      stall_len = 2'd0;
  end

  // Outputs are combinational so a hazard stalls in the cycle it is seen;
  // reset is folded in so they take their idle values without a clock.
  always_comb begin
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    idExBubble = 1'b0;
    ifIdFlush  = 1'b0;
    pipeFreeze = 1'b0;
    if (reset) begin
      if (memBusy) begin
        pipeFreeze = 1'b1;
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
      end else if (state == STALL || stall_len != 2'd0) begin
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        idExBubble = 1'b1;
      end else if (branchTaken) begin
        ifIdFlush  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      remaining   <= 2'd0;
      stallCount  <= 16'd0;
      freezeCount <= 16'd0;
    end else if (memBusy) begin
      if (freezeCount != 16'hFFFF)
        freezeCount <= freezeCount + 16'd1;
    end else begin
      if (idExBubble && stallCount != 16'hFFFF)
        stallCount <= stallCount + 16'd1;
      case (state)
        RUN: begin
          // The first bubble of a two-cycle stall is issued here in RUN.
          if (stall_len == 2'd2) begin
            state     <= STALL;
            remaining <= 2'd1;
          end
        end
        STALL: begin
          if (remaining <= 2'd1) begin
            remaining <= 2'd0;
            state     <= RUN;
          end else begin
            remaining <= remaining - 2'd1;
          end
        end
        default: begin
          state     <= RUN;
          remaining <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_detection.sv
// tb/tb_hazard_detection.sv - directed scoreboard bench for hazard_detection
module tb_hazard_detection;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rsIfId, rtIfId, rtIdEx, rdIdEx, rdExMem;
  logic        useRtId, branchId, branchTaken, memReadIdEx, regWriteIdEx, memReadExMem, memBusy;
  logic        pcWrite, ifIdWrite, idExBubble, ifIdFlush, pipeFreeze;
  logic [15:0] stallCount, freezeCount;

  typedef struct {
    string       tag;
    logic [4:0]  ctl;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] m_stall = 16'd0;
  logic [15:0] m_freeze = 16'd0;

  // ctl packing: {pcWrite, ifIdWrite, idExBubble, ifIdFlush, pipeFreeze}
  localparam logic [4:0] NORM  = 5'b11000;
  localparam logic [4:0] BUB   = 5'b00100;
  localparam logic [4:0] FLUSH = 5'b11010;
  localparam logic [4:0] FRZ   = 5'b00001;

  hazard_detection dut (
    .clock(clock), .reset(reset),
    .rsIfId(rsIfId), .rtIfId(rtIfId), .useRtId(useRtId),
    .branchId(branchId), .branchTaken(branchTaken),
    .memReadIdEx(memReadIdEx), .regWriteIdEx(regWriteIdEx),
    .rtIdEx(rtIdEx), .rdIdEx(rdIdEx),
    .memReadExMem(memReadExMem), .rdExMem(rdExMem),
    .memBusy(memBusy),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .idExBubble(idExBubble),
    .ifIdFlush(ifIdFlush), .pipeFreeze(pipeFreeze),
    .stallCount(stallCount), .freezeCount(freezeCount)
  );

  always #5 clock = ~clock;

  task automatic idle();
    rsIfId = 0; rtIfId = 0; rtIdEx = 0; rdIdEx = 0; rdExMem = 0;
    useRtId = 0; branchId = 0; branchTaken = 0; memReadIdEx = 0;
    regWriteIdEx = 0; memReadExMem = 0; memBusy = 0;
  endtask

  task automatic check_now(input string tag, input logic [4:0] ctl,
                           input logic [15:0] sc, input logic [15:0] fc);
    logic [4:0] got;
    got = {pcWrite, ifIdWrite, idExBubble, ifIdFlush, pipeFreeze};
    checks++;
    assert (got === ctl) else begin
      failures++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, got, ctl);
    end
    checks++;
    assert (stallCount === sc) else begin
      failures++;
      $error("FAIL %s stallCount observed=%0d expected=%0d", tag, stallCount, sc);
    end
    checks++;
    assert (freezeCount === fc) else begin
      failures++;
      $error("FAIL %s freezeCount observed=%0d expected=%0d", tag, freezeCount, fc);
    end
  endtask

  // Inputs already driven for this cycle; expectation queued, checked at negedge,
  // then the counter model advances for the coming edge.
  task automatic cyc(input string tag, input logic [4:0] ctl);
    exp_t e;
    exp_q.push_back('{tag, ctl, m_stall, m_freeze});
    @(negedge clock);
    e = exp_q.pop_front();
    check_now(e.tag, e.ctl, e.sc, e.fc);
    if (ctl[0]) begin
      if (m_freeze != 16'hFFFF) m_freeze = m_freeze + 16'd1;
    end else if (ctl[2]) begin
      if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic br_load_hazard();
    idle(); branchId = 1; rsIfId = 9; memReadIdEx = 1; rtIdEx = 9;
  endtask

  initial begin
    // Reset forces idle outputs even with hazards and memBusy present
    idle(); memBusy = 1; memReadIdEx = 1; rtIdEx = 8; rsIfId = 8;
    #2;
    check_now("reset_hold", NORM, 16'd0, 16'd0);
    idle();
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;

    cyc("idle0", NORM);

    // Load-use on rs
    memReadIdEx = 1; rtIdEx = 8; rsIfId = 8;
    cyc("loaduse", BUB);
    idle();
    cyc("loaduse_after", NORM);

    // Branch on a load result: two bubbles, then a taken branch flushes
    br_load_hazard();
    cyc("brload_b1", BUB);
    idle(); branchTaken = 1;
    cyc("brload_b2_ignores", BUB);
    branchId = 1; branchTaken = 1;
    cyc("brtaken_flush", FLUSH);
    idle();
    cyc("after_flush", NORM);

    // Register zero never matches
    memReadIdEx = 1; rtIdEx = 0; rsIfId = 0;
    cyc("reg_zero", NORM);

    // Branch on ALU result in EX
    idle(); branchId = 1; regWriteIdEx = 1; rdIdEx = 5; rtIfId = 5;
    cyc("br_ex", BUB);
    // ALU result, but not a branch
    branchId = 0;
    cyc("no_branch_alu", NORM);

    // Branch on load in MEM
    idle(); branchId = 1; memReadExMem = 1; rdExMem = 7; rsIfId = 7;
    cyc("br_mem", BUB);

    // Load-use on rt only counts when rt is read
    idle(); memReadIdEx = 1; rtIdEx = 12; rtIfId = 12; useRtId = 0;
    cyc("rt_unused", NORM);
    useRtId = 1;
    cyc("rt_used", BUB);

    // Freeze in RUN for 3 cycles, with a hazard present under the freeze
    idle(); memBusy = 1;
    cyc("frz_run1", FRZ);
    cyc("frz_run2", FRZ);
    memReadIdEx = 1; rtIdEx = 3; rsIfId = 3;
    cyc("frz_run3", FRZ);
    idle();
    cyc("frz_run_done", NORM);

    // Freeze while in STALL holds the remaining bubble
    br_load_hazard();
    cyc("frz_stall_enter", BUB);
    idle(); memBusy = 1;
    cyc("frz_stall1", FRZ);
    cyc("frz_stall2", FRZ);
    memBusy = 0;
    cyc("frz_stall_bubble", BUB);
    cyc("frz_stall_run", NORM);

    // Reset in the middle of a STALL, checked without a clock edge
    br_load_hazard();
    cyc("rst_stall_enter", BUB);
    idle();
    #2;
    reset = 1'b0;
    #1;
    check_now("reset_mid_stall", NORM, 16'd0, 16'd0);
    m_stall = 16'd0; m_freeze = 16'd0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    cyc("post_reset_run", NORM);
    memReadIdEx = 1; rtIdEx = 4; rsIfId = 4;
    cyc("post_reset_loaduse", BUB);
    idle();
    cyc("post_reset_idle", NORM);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
